write_back_stage: RTL and testbench
===================================

Name: write_back_stage

Overview:
Parametrised, registered successor to the combinational write-back mux of the hybrid ARM/MIPS pipeline. Captures one MEM/WB transaction per cycle, selects among NSRC result sources, and drives a single-cycle commit to the register file. IO reads use a request/acknowledge handshake with a bounded timeout; the stage stalls upstream while an IO read is outstanding. Synchronous flush is supported.

Parameters:
DATA_W, 32, width of every data source and of OutData
REG_ADDR_W, 5, destination register index width
NSRC, 4, number of selectable result sources (slot 0 ALU result, 1 memory read data, 2 memory read data P, 3+ spare)
SEL_W, $clog2(NSRC), MemToReg width
IO_TIMEOUT, 16, max IOReq-high cycles before abort; 0 = wait forever

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
InValid  in  1  upstream transaction valid
InReady  out  1  stage can accept; transfer when InValid && InReady
Flush  in  1  synchronous kill of incoming/outstanding transaction
PCSrc  in  1  branch/PC-write flag, passed through
RegWrite  in  1  register-file write enable, passed through
IOFlag  in  1  result comes from IO port instead of SrcData
MemToReg  in  SEL_W  source select
SrcData  in  NSRC*DATA_W  packed sources, slot i at [i*DATA_W +: DATA_W]
Rd  in  REG_ADDR_W  destination register
IOReq  out  1  IO read request, held until IOAck or abort
IOAck  in  1  IO data valid on IOIn this cycle
IOIn  in  DATA_W  IO read data
OutValid  out  1  one-cycle commit strobe
OutData  out  DATA_W  write-back data
RdOut  out  REG_ADDR_W  write-back register index
RegWriteOut  out  1  qualified write enable (0 unless OutValid)
PCSrcOut  out  1  qualified PCSrc (0 unless OutValid)
IOErr  out  1  one-cycle pulse with OutValid on IO timeout

Behaviour:
- Reset (async, reset_n=0): state IDLE, timeout counter 0, all outputs 0 (InReady 0 while in reset, 1 the first cycle after release).
- States: IDLE, IO_WAIT. InReady = (state==IDLE).
- IDLE, accept with IOFlag=0, Flush=0: next cycle OutValid=1, OutData=SrcData[MemToReg], RdOut=Rd, RegWriteOut=RegWrite, PCSrcOut=PCSrc. Latency 1; back-to-back accepts every cycle.
- MemToReg >= NSRC: commit with OutData=0, RegWriteOut=0.
- IDLE, accept with IOFlag=1, Flush=0: latch Rd/RegWrite/PCSrc; go IO_WAIT; IOReq=1 from next cycle; counter cleared.
- IO_WAIT: IOAck sampled high -> next cycle OutValid=1, OutData=IOIn (as sampled), latched control fields; IOReq=0; state IDLE (new accept allowed that same cycle).
- IO_WAIT timeout: counter increments per IOReq-high cycle without IOAck; after IO_TIMEOUT such cycles -> next cycle OutValid=1, IOErr=1, OutData=0, RegWriteOut=0, PCSrcOut=latched; IOReq=0; IDLE. IOAck on the final counted cycle wins over timeout.
- Flush: in IDLE, a transaction accepted the same cycle is dropped (no OutValid). In IO_WAIT, abort: IOReq=0 next cycle, IDLE, no OutValid, no IOErr. Flush coincident with IOAck: flush wins.
- Idle cycles: OutValid/RegWriteOut/PCSrcOut/IOErr = 0; OutData and RdOut hold last committed values.
- Reset mid IO_WAIT: IOReq drops immediately (async), transaction lost.

Test Plan:
- SrcData = {0x7F, 0x55, 0x16} in slots 2, 1, 0, Rd=6, RegWrite=1; MemToReg=1, 0, 2 on three consecutive cycles -> OutValid three consecutive cycles, OutData 0x55, 0x16, 0x7F, RdOut=6, RegWriteOut=1.
- IOFlag=1, IOIn=0x3C, IOAck raised 3 cycles after IOReq -> InReady=0 throughout, OutValid one cycle after ack, OutData=0x3C, IOErr=0.
- IOFlag=1, IO_TIMEOUT=16, no IOAck -> IOReq high exactly 16 cycles, then OutValid=1, IOErr=1, RegWriteOut=0, OutData=0.
- Flush asserted in IO_WAIT together with IOAck -> no OutValid, IOReq low next cycle, InReady=1.
- MemToReg=5 with NSRC=4 (SEL_W=3 override) -> OutValid=1, OutData=0, RegWriteOut=0.
- reset_n pulsed low during IO_WAIT -> all outputs 0 immediately; next accept with MemToReg=0 commits 0x16 normally.

Source files
------------

// File: rtl/write_back_stage.sv
// -----------------------------------------------------------------------------
// write_back_stage
//
// Registered write-back stage. It captures one MEM/WB transaction per cycle,
// selects the result from NSRC packed sources or from an IO read port, and
// issues a single-cycle commit to the register file.
//
// Handshake: an upstream transfer happens on a rising edge where
// InValid && InReady. InReady is high only in IDLE and only after the first
// clock following reset release. An IO read holds IOReq high until IOAck is
// sampled high, the timeout expires, or Flush aborts it. No other transfer is
// accepted while IOReq is high.
//
// Ports:
//   clk, reset_n                  clock (rising edge), async active-low reset
//   InValid / InReady             upstream handshake
//   Flush                         kill the incoming or outstanding transaction
//   PCSrc, RegWrite, Rd           control fields carried to the commit
//   IOFlag                        result comes from the IO port
//   MemToReg, SrcData             source select and packed source data
//   IOReq / IOAck, IOIn           IO read request, acknowledge and data
//   OutValid, OutData, RdOut      commit strobe, data and register index
//   RegWriteOut, PCSrcOut         commit-qualified control
//   IOErr                         IO timeout marker, pulses with OutValid
//   dbg_state                     1 while an IO read is outstanding
// -----------------------------------------------------------------------------
module write_back_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int NSRC       = 4,
  parameter int SEL_W      = (NSRC > 1) ? $clog2(NSRC) : 1,
  parameter int IO_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   InValid,
  output logic                   InReady,
  input  logic                   Flush,
  input  logic                   PCSrc,
  input  logic                   RegWrite,
  input  logic                   IOFlag,
  input  logic [SEL_W-1:0]       MemToReg,
  input  logic [NSRC*DATA_W-1:0] SrcData,
  input  logic [REG_ADDR_W-1:0]  Rd,
  output logic                   IOReq,
  input  logic                   IOAck,
  input  logic [DATA_W-1:0]      IOIn,
  output logic                   OutValid,
  output logic [DATA_W-1:0]      OutData,
  output logic [REG_ADDR_W-1:0]  RdOut,
  output logic                   RegWriteOut,
  output logic                   PCSrcOut,
  output logic                   IOErr,
  output logic                   dbg_state
);

  // The counter only has to reach IO_TIMEOUT-1: the cycle that would make it
  // IO_TIMEOUT is the one that triggers the abort.
  localparam int CNT_W = (IO_TIMEOUT > 1) ? $clog2(IO_TIMEOUT) : 1;
  localparam int LAST  = (IO_TIMEOUT > 0) ? IO_TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST);

  typedef enum logic {
    IDLE    = 1'b0,
    IO_WAIT = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ready_en_q;

  // Control fields held across an IO read.
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic                  rw_q, rw_d;
  logic                  pc_q, pc_d;

  // Registered commit outputs.
  logic                  out_valid_q, out_valid_d;
  logic [DATA_W-1:0]     out_data_q, out_data_d;
  logic [REG_ADDR_W-1:0] rd_out_q, rd_out_d;
  logic                  rw_out_q, rw_out_d;
  logic                  pc_out_q, pc_out_d;
  logic                  io_err_q, io_err_d;

  logic                  accept;
  logic                  sel_ok;
  logic                  timeout_hit;
  logic [DATA_W-1:0]     sel_data;

  assign InReady     = ready_en_q && (state_q == IDLE);
  assign IOReq       = (state_q == IO_WAIT);
  assign dbg_state   = (state_q == IO_WAIT);
  assign accept      = InValid && InReady;
  assign timeout_hit = (IO_TIMEOUT != 0) && (cnt_q == CNT_LAST);

  // An out-of-range select still commits, but as a harmless zero that does
  // not write the register file.
  assign sel_ok = (32'(MemToReg) < 32'(NSRC));

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (32'(MemToReg) == 32'(i)) sel_data = SrcData[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    rw_d        = rw_q;
    pc_d        = pc_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    rd_out_d    = rd_out_q;
    rw_out_d    = 1'b0;
    pc_out_d    = 1'b0;
    io_err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept && !Flush) begin
          if (IOFlag) begin
            state_d = IO_WAIT;
            cnt_d   = '0;
            rd_d    = Rd;
            rw_d    = RegWrite;
            pc_d    = PCSrc;
          end else begin
            out_valid_d = 1'b1;
            out_data_d  = sel_ok ? sel_data : '0;
            rd_out_d    = Rd;
            rw_out_d    = RegWrite && sel_ok;
            pc_out_d    = PCSrc;
          end
        end
      end

      IO_WAIT: begin
        // Priority: flush, then acknowledge, then timeout. An acknowledge on
        // the last counted cycle therefore still delivers data.
        if (Flush) begin
          state_d = IDLE;
        end else if (IOAck) begin
          state_d     = IDLE;
          out_valid_d = 1'b1;
          out_data_d  = IOIn;
          rd_out_d    = rd_q;
          rw_out_d    = rw_q;
          pc_out_d    = pc_q;
        end else if (timeout_hit) begin
          state_d     = IDLE;
          out_valid_d = 1'b1;
          out_data_d  = '0;
          rd_out_d    = rd_q;
          rw_out_d    = 1'b0;
          pc_out_d    = pc_q;
          io_err_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ready_en_q  <= 1'b0;
      rd_q        <= '0;
      rw_q        <= 1'b0;
      pc_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      rd_out_q    <= '0;
      rw_out_q    <= 1'b0;
      pc_out_q    <= 1'b0;
      io_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_en_q  <= 1'b1;
      rd_q        <= rd_d;
      rw_q        <= rw_d;
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      rd_out_q    <= rd_out_d;
      rw_out_q    <= rw_out_d;
      pc_out_q    <= pc_out_d;
      io_err_q    <= io_err_d;
    end
  end

  assign OutValid    = out_valid_q;
  assign OutData     = out_data_q;
  assign RdOut       = rd_out_q;
  assign RegWriteOut = rw_out_q;
  assign PCSrcOut    = pc_out_q;
  assign IOErr       = io_err_q;

endmodule

// File: tb/tb_write_back_stage.sv
module tb_write_back_stage;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NSRC       = 4;
  localparam int SEL_W      = 3;
  localparam int IO_TIMEOUT = 16;

  // Expected-commit entry: {cycle, err, pc, rw, rd, data}
  localparam int D_LO  = 0;
  localparam int RD_LO = DATA_W;
  localparam int RW_B  = DATA_W + REG_ADDR_W;
  localparam int PC_B  = RW_B + 1;
  localparam int ER_B  = RW_B + 2;
  localparam int CY_LO = RW_B + 3;
  localparam int EW    = CY_LO + 32;

  logic                   clk;
  logic                   reset_n;
  logic                   InValid;
  logic                   InReady;
  logic                   Flush;
  logic                   PCSrc;
  logic                   RegWrite;
  logic                   IOFlag;
  logic [SEL_W-1:0]       MemToReg;
  logic [NSRC*DATA_W-1:0] SrcData;
  logic [REG_ADDR_W-1:0]  Rd;
  logic                   IOReq;
  logic                   IOAck;
  logic [DATA_W-1:0]      IOIn;
  logic                   OutValid;
  logic [DATA_W-1:0]      OutData;
  logic [REG_ADDR_W-1:0]  RdOut;
  logic                   RegWriteOut;
  logic                   PCSrcOut;
  logic                   IOErr;
  logic                   dbg_state;

  write_back_stage #(
    .DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .NSRC(NSRC),
    .SEL_W(SEL_W), .IO_TIMEOUT(IO_TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .InValid(InValid), .InReady(InReady),
    .Flush(Flush), .PCSrc(PCSrc), .RegWrite(RegWrite), .IOFlag(IOFlag),
    .MemToReg(MemToReg), .SrcData(SrcData), .Rd(Rd), .IOReq(IOReq),
    .IOAck(IOAck), .IOIn(IOIn), .OutValid(OutValid), .OutData(OutData),
    .RdOut(RdOut), .RegWriteOut(RegWriteOut), .PCSrcOut(PCSrcOut),
    .IOErr(IOErr), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;

  logic [EW-1:0]         exp_q[$];
  bit                    exp_busy = 1'b0;  // an IO read is outstanding
  bit                    alive    = 1'b0;  // first edge after reset seen
  logic [DATA_W-1:0]     last_data = '0;
  logic [REG_ADDR_W-1:0] last_rd   = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input int info);
    checks++;
    failures++;
    $display("FAIL %s: info %0d (cycle %0d)", name, info, cyc);
  endtask

  function automatic logic [EW-1:0] mk(input int c, input logic err, input logic pc,
                                       input logic rw, input logic [REG_ADDR_W-1:0] rd,
                                       input logic [DATA_W-1:0] d);
    return {32'(c), err, pc, rw, rd, d};
  endfunction

  // Source-select rule: slot m of the packed bus, zero when m names no slot.
  function automatic logic [DATA_W-1:0] model_sel(input logic [NSRC*DATA_W-1:0] src,
                                                  input int m);
    logic [DATA_W-1:0] slots [NSRC];
    for (int i = 0; i < NSRC; i++) slots[i] = src[i*DATA_W +: DATA_W];
    if (m < NSRC) return slots[m];
    return '0;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (reset_n) begin
      chk("in_ready", InReady, alive && !exp_busy);
      chk("io_req", IOReq, exp_busy);
      if (OutValid) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_commit", int'(OutData));
        end else begin
          e = exp_q.pop_front();
          chk("commit_cycle", cyc, e[CY_LO +: 32]);
          chk("out_data", OutData, e[D_LO +: DATA_W]);
          chk("rd_out", RdOut, e[RD_LO +: REG_ADDR_W]);
          chk("reg_write_out", RegWriteOut, e[RW_B]);
          chk("pc_src_out", PCSrcOut, e[PC_B]);
          chk("io_err", IOErr, e[ER_B]);
          last_data = e[D_LO +: DATA_W];
          last_rd   = e[RD_LO +: REG_ADDR_W];
        end
      end else begin
        if (exp_q.size() > 0) begin
          e = exp_q[0];
          if (int'(e[CY_LO +: 32]) <= cyc) begin
            void'(exp_q.pop_front());
            fail_now("missing_commit", int'(e[CY_LO +: 32]));
          end
        end
        chk("idle_reg_write", RegWriteOut, 1'b0);
        chk("idle_pc_src", PCSrcOut, 1'b0);
        chk("idle_io_err", IOErr, 1'b0);
        chk("hold_data", OutData, last_data);
        chk("hold_rd", RdOut, last_rd);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic junk();
    InValid  = 1'($urandom);
    Flush    = 1'($urandom);
    IOFlag   = 1'($urandom);
    MemToReg = SEL_W'($urandom);
    SrcData  = {$urandom, $urandom, $urandom, $urandom};
    Rd       = REG_ADDR_W'($urandom);
    RegWrite = 1'($urandom);
    PCSrc    = 1'($urandom);
    IOAck    = 1'($urandom);
    IOIn     = $urandom;
  endtask

  task automatic idle_cycle();
    junk();
    InValid = 1'b0;
    tick();
  endtask

  task automatic alu_txn(input logic [SEL_W-1:0] m, input logic [NSRC*DATA_W-1:0] src,
                         input logic [REG_ADDR_W-1:0] rd, input logic rw, input logic pc,
                         input logic [DATA_W-1:0] exp_data, input logic exp_rw);
    junk();
    InValid = 1'b1; Flush = 1'b0; IOFlag = 1'b0;
    MemToReg = m; SrcData = src; Rd = rd; RegWrite = rw; PCSrc = pc;
    exp_q.push_back(mk(cyc + 1, 1'b0, pc, exp_rw, rd, exp_data));
    tick();
  endtask

  task automatic alu_rand();
    logic [SEL_W-1:0]       m;
    logic [NSRC*DATA_W-1:0] src;
    logic [REG_ADDR_W-1:0]  rd;
    logic                   rw, pc;
    m   = SEL_W'($urandom_range(0, 7));
    src = {$urandom, $urandom, $urandom, $urandom};
    rd  = REG_ADDR_W'($urandom);
    rw  = 1'($urandom);
    pc  = 1'($urandom);
    alu_txn(m, src, rd, rw, pc, model_sel(src, int'(m)), rw && (int'(m) < NSRC));
  endtask

  // IO read: ack_at = IOReq-high cycle index (0-based) of the acknowledge,
  // flush_at = index of a flush (-1 = none); an ack never arriving within
  // IO_TIMEOUT request cycles ends in a timeout commit.
  task automatic io_txn(input int ack_at, input int flush_at, input logic flush_ack,
                        input logic [DATA_W-1:0] io_data, input logic [REG_ADDR_W-1:0] rd,
                        input logic rw, input logic pc);
    bit done;
    junk();
    InValid = 1'b1; Flush = 1'b0; IOFlag = 1'b1; Rd = rd; RegWrite = rw; PCSrc = pc;
    tick();
    exp_busy = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 64 && !done; k++) begin
      junk();
      Flush = 1'b0;
      IOAck = 1'b0;
      if (k == flush_at) begin
        Flush = 1'b1;
        IOAck = flush_ack;
        done  = 1'b1;
      end else if (k == ack_at) begin
        IOAck = 1'b1;
        IOIn  = io_data;
        exp_q.push_back(mk(cyc + 1, 1'b0, pc, rw, rd, io_data));
        done  = 1'b1;
      end else if (k == IO_TIMEOUT - 1) begin
        exp_q.push_back(mk(cyc + 1, 1'b1, pc, 1'b0, rd, '0));
        done  = 1'b1;
      end
      tick();
    end
    exp_busy = 1'b0;
  endtask

  task automatic flush_accept();
    junk();
    InValid = 1'b1;
    Flush   = 1'b1;
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_in_ready"}, InReady, 1'b0);
    chk({tag, "_io_req"}, IOReq, 1'b0);
    chk({tag, "_out_valid"}, OutValid, 1'b0);
    chk({tag, "_out_data"}, OutData, '0);
    chk({tag, "_rd_out"}, RdOut, '0);
    chk({tag, "_reg_write"}, RegWriteOut, 1'b0);
    chk({tag, "_pc_src"}, PCSrcOut, 1'b0);
    chk({tag, "_io_err"}, IOErr, 1'b0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    InValid = 1'b0;
    reset_n = 1'b1;
    tick();
    alive = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  logic [NSRC*DATA_W-1:0] plan_src;

  initial begin
    reset_n = 1'b0;
    InValid = 1'b0; Flush = 1'b0; PCSrc = 1'b0; RegWrite = 1'b0; IOFlag = 1'b0;
    MemToReg = '0; SrcData = '0; Rd = '0; IOAck = 1'b0; IOIn = '0;
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    release_reset();

    plan_src = {32'h0, 32'h7F, 32'h55, 32'h16};

    // Three back-to-back selects.
    alu_txn(3'd1, plan_src, 5'd6, 1'b1, 1'b0, 32'h55, 1'b1);
    alu_txn(3'd0, plan_src, 5'd6, 1'b1, 1'b0, 32'h16, 1'b1);
    alu_txn(3'd2, plan_src, 5'd6, 1'b1, 1'b0, 32'h7F, 1'b1);
    idle_cycle();

    // IO read acknowledged on the fourth request cycle.
    io_txn(3, -1, 1'b0, 32'h3C, 5'd9, 1'b1, 1'b1);
    idle_cycle();

    // IO timeout: no acknowledge at all.
    io_txn(1000, -1, 1'b0, 32'h0, 5'd12, 1'b1, 1'b1);
    idle_cycle();

    // Acknowledge on the final counted cycle beats the timeout.
    io_txn(IO_TIMEOUT - 1, -1, 1'b0, 32'hA5A5_0001, 5'd3, 1'b1, 1'b0);

    // Flush together with IOAck in IO_WAIT.
    io_txn(1000, 2, 1'b1, 32'h0, 5'd7, 1'b1, 1'b1);
    idle_cycle();

    // Out-of-range select commits zero with no register write.
    alu_txn(3'd5, plan_src, 5'd4, 1'b1, 1'b1, 32'h0, 1'b0);

    // Flush on an accept drops it.
    flush_accept();
    idle_cycle();

    // Reset in the middle of an IO read.
    junk();
    InValid = 1'b1; Flush = 1'b0; IOFlag = 1'b1;
    tick();
    exp_busy = 1'b1;
    junk(); Flush = 1'b0; IOAck = 1'b0;
    tick();
    junk(); Flush = 1'b0; IOAck = 1'b0;
    #2;
    reset_n = 1'b0;
    exp_busy = 1'b0;
    alive = 1'b0;
    exp_q.delete();
    last_data = '0;
    last_rd = '0;
    #1;
    check_all_zero("mid_io_reset");
    release_reset();
    alu_txn(3'd0, plan_src, 5'd6, 1'b1, 1'b0, 32'h16, 1'b1);

    // Randomized traffic.
    for (int t = 0; t < 300; t++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind <= 4) alu_rand();
      else if (kind <= 6)
        io_txn($urandom_range(0, 20), -1, 1'b0, $urandom, REG_ADDR_W'($urandom),
               1'($urandom), 1'($urandom));
      else if (kind == 7)
        io_txn($urandom_range(0, 20), $urandom_range(0, 5), 1'($urandom), $urandom,
               REG_ADDR_W'($urandom), 1'($urandom), 1'($urandom));
      else if (kind == 8) flush_accept();
      else idle_cycle();
    end

    repeat (3) idle_cycle();
    chk("drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
